// File: rtl/lc3_mem_io_ctrl.sv
// LC-3 MAR/MDR and memory/I-O access controller with wait-stated memory handshake
// and the memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR) registers.
module lc3_mem_io_ctrl #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 16,
   parameter int                MEM_LAT   = 4,
   parameter logic [ADDR_W-1:0] KBSR_ADDR = 16'hFE00,
   parameter logic [ADDR_W-1:0] KBDR_ADDR = 16'hFE02,
   parameter logic [ADDR_W-1:0] DSR_ADDR  = 16'hFE04,
   parameter logic [ADDR_W-1:0] DDR_ADDR  = 16'hFE06
) (
   input  logic              i_Clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              ld_mar,
   input  logic              ld_mdr,
   input  logic              mio_en,
   input  logic              rw,
   output logic              r,
   output logic [ADDR_W-1:0] mar_out,
   output logic [DATA_W-1:0] mdr_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              kbd_valid,
   input  logic [7:0]        kbd_data,
   input  logic              dsp_ready,
   output logic              ddr_valid,
   output logic [7:0]        ddr_data,
   output logic              kbd_int
);

   localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);
   // Device slot order: 0 KBSR, 1 KBDR, 2 DSR, 3 DDR
   localparam logic [4*ADDR_W-1:0] DEV_ADDRS = {DDR_ADDR, DSR_ADDR, KBDR_ADDR, KBSR_ADDR};

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_start;

   logic [ADDR_W-1:0] r_mar;
   logic [DATA_W-1:0] r_mdr;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rw;
   logic [3:0]        r_sel;

   logic              r_kb_full;
   logic              r_kb_ie;
   logic              r_kb_ovr;
   logic [7:0]        r_kbdr;
   logic              r_dsr_rdy;
   logic [7:0]        r_ddr;
   logic              r_ddr_valid;

   logic [3:0]        w_mar_hit;
   logic              w_done;
   logic              w_last;
   logic [DATA_W-1:0] w_rd;
   logic              w_rd_acc;
   logic              w_kbdr_rd;
   logic              w_kbsr_wr;
   logic              w_ddr_wr;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         assign w_mar_hit[gi] = (r_mar == DEV_ADDRS[gi*ADDR_W +: ADDR_W]);
      end
   endgenerate

   // Strobes are gated by reset so an access interrupted by reset never writes or completes
   assign w_done    = (r_state == S_DONE) && reset;
   assign w_last    = (r_state == S_MEM) && (r_cnt == '0);
   assign w_rd_acc  = w_done && !r_rw;
   assign w_kbdr_rd = w_rd_acc && r_sel[1];
   assign w_kbsr_wr = w_done && r_rw && r_sel[0];
   assign w_ddr_wr  = w_done && r_rw && r_sel[3];

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mio_en) begin
               w_start = 1'b1;
               if (|w_mar_hit) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_MEM;
                  w_cnt_next   = CNT_LOAD;
               end
            end
         end
         S_MEM: begin
            if (!mio_en) begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else if (r_cnt == '0) begin
               w_state_next = S_DONE;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd = '0;
      if (r_sel[0]) begin
         w_rd[15] = r_kb_full;
         w_rd[14] = r_kb_ie;
      end else if (r_sel[1]) begin
         w_rd[7:0] = r_kbdr;
      end else if (r_sel[2]) begin
         w_rd[15] = r_dsr_rdy;
      end else if (!r_sel[3]) begin
         w_rd = r_rdata;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mar       <= '0;
         r_mdr       <= '0;
         r_rdata     <= '0;
         r_rw        <= 1'b0;
         r_sel       <= '0;
         r_kb_full   <= 1'b0;
         r_kb_ie     <= 1'b0;
         r_kb_ovr    <= 1'b0;
         r_kbdr      <= '0;
         r_dsr_rdy   <= 1'b1;
         r_ddr       <= '0;
         r_ddr_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_ddr_valid <= w_ddr_wr;

         if (w_start) begin
            r_rw  <= rw;
            r_sel <= w_mar_hit;
         end
         if (w_last && mio_en) begin
            r_rdata <= mem_rdata;
         end
         if (ld_mar) begin
            r_mar <= bus_in[ADDR_W-1:0];
         end
         if (ld_mdr) begin
            if (!mio_en) begin
               r_mdr <= bus_in;
            end else if (w_rd_acc) begin
               r_mdr <= w_rd;
            end
         end

         // A character arriving during a KBDR read is accepted as the next one
         if (w_kbdr_rd) begin
            r_kb_ovr  <= 1'b0;
            r_kb_full <= kbd_valid;
            if (kbd_valid) begin
               r_kbdr <= kbd_data;
            end
         end else if (kbd_valid) begin
            if (r_kb_full) begin
               r_kb_ovr <= 1'b1;
            end else begin
               r_kbdr    <= kbd_data;
               r_kb_full <= 1'b1;
            end
         end
         if (w_kbsr_wr) begin
            r_kb_ie <= r_mdr[14];
         end

         if (w_ddr_wr) begin
            r_ddr     <= r_mdr[7:0];
            r_dsr_rdy <= 1'b0;
         end else if (dsp_ready) begin
            r_dsr_rdy <= 1'b1;
         end
      end
   end

   assign r         = w_done;
   assign mar_out   = r_mar;
   assign mdr_out   = r_mdr;
   assign mem_addr  = r_mar;
   assign mem_wdata = r_mdr;
   assign mem_en    = (r_state == S_MEM);
   assign mem_we    = w_last && r_rw && mio_en && reset;
   assign ddr_valid = r_ddr_valid;
   assign ddr_data  = r_ddr;
   assign kbd_int   = r_kb_full && r_kb_ie;

endmodule

// File: tb/tb_lc3_mem_io_ctrl.sv
// Directed bench for lc3_mem_io_ctrl: an access-level reference model checked every cycle
// plus literal expectations for latency, strobes and device register behaviour.
module tb_lc3_mem_io_ctrl;
   localparam int MEM_LAT = 4;
   localparam logic [15:0] A_KBSR = 16'hFE00;
   localparam logic [15:0] A_KBDR = 16'hFE02;
   localparam logic [15:0] A_DSR  = 16'hFE04;
   localparam logic [15:0] A_DDR  = 16'hFE06;

   logic i_Clk = 1'b0;
   logic reset = 1'b0;
   logic [15:0] bus_in = '0;
   logic ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, rw = 1'b0;
   logic r, mem_en, mem_we, ddr_valid, kbd_int;
   logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata, mem_rdata;
   logic kbd_valid = 1'b0, dsp_ready = 1'b0;
   logic [7:0] kbd_data = '0, ddr_data;
   logic [15:0] rdata_v = '0;

   assign mem_rdata = rdata_v;

   lc3_mem_io_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(MEM_LAT)) dut (
      .i_Clk(i_Clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
      .mio_en(mio_en), .rw(rw), .r(r), .mar_out(mar_out), .mdr_out(mdr_out),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
      .dsp_ready(dsp_ready), .ddr_valid(ddr_valid), .ddr_data(ddr_data), .kbd_int(kbd_int)
   );

   always #5 i_Clk = ~i_Clk;

   int n_tests = 0;
   int n_fail  = 0;
   int ddr_pulses = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: an access is tracked by its age in cycles since it was accepted
   logic [15:0] m_mar, m_mdr, m_addr, m_rdata;
   logic [7:0]  m_kbdr, m_ddr;
   logic m_full, m_ie, m_ovr, m_dsr, m_ddr_valid, m_busy, m_dev, m_rw;
   int   m_age;

   function automatic logic is_dev(input logic [15:0] a);
      return (a == A_KBSR) || (a == A_KBDR) || (a == A_DSR) || (a == A_DDR);
   endfunction

   always @(posedge i_Clk) begin : model
      logic [15:0] rd;
      logic kclr, dwr, full_n, ovr_n;
      int L;
      if (!reset) begin
         m_mar <= '0; m_mdr <= '0; m_kbdr <= '0; m_ddr <= '0; m_rdata <= '0; m_addr <= '0;
         m_full <= 1'b0; m_ie <= 1'b0; m_ovr <= 1'b0; m_dsr <= 1'b1; m_ddr_valid <= 1'b0;
         m_busy <= 1'b0; m_dev <= 1'b0; m_rw <= 1'b0; m_age <= 0;
      end else begin
         L = m_dev ? 1 : MEM_LAT + 1;
         kclr = 1'b0; dwr = 1'b0; rd = m_rdata;
         m_ddr_valid <= 1'b0;
         if (m_busy && m_age == L) begin
            if (m_addr == A_KBSR)      rd = {m_full, m_ie, 14'b0};
            else if (m_addr == A_KBDR) rd = {8'h00, m_kbdr};
            else if (m_addr == A_DSR)  rd = {m_dsr, 15'b0};
            else if (m_addr == A_DDR)  rd = 16'h0000;
            if (!m_rw) begin
               kclr = (m_addr == A_KBDR);
               if (ld_mdr && mio_en) m_mdr <= rd;
            end else begin
               if (m_addr == A_KBSR) m_ie <= m_mdr[14];
               if (m_addr == A_DDR) begin
                  dwr = 1'b1; m_ddr <= m_mdr[7:0]; m_ddr_valid <= 1'b1;
               end
            end
         end
         full_n = kclr ? 1'b0 : m_full;
         ovr_n  = kclr ? 1'b0 : m_ovr;
         if (kbd_valid) begin
            if (full_n) ovr_n = 1'b1;
            else begin full_n = 1'b1; m_kbdr <= kbd_data; end
         end
         m_full <= full_n;
         m_ovr  <= ovr_n;
         if (dwr) m_dsr <= 1'b0;
         else if (dsp_ready) m_dsr <= 1'b1;
         if (ld_mdr && !mio_en) m_mdr <= bus_in;
         if (ld_mar) m_mar <= bus_in;
         if (m_busy) begin
            if (!m_dev && m_age <= MEM_LAT && !mio_en) m_busy <= 1'b0;
            else begin
               if (!m_dev && m_age == MEM_LAT) m_rdata <= mem_rdata;
               if (m_age == L) m_busy <= 1'b0;
               else m_age <= m_age + 1;
            end
         end else if (mio_en) begin
            m_busy <= 1'b1; m_age <= 1; m_addr <= m_mar; m_rw <= rw; m_dev <= is_dev(m_mar);
         end
      end
   end

   always @(negedge i_Clk) begin : compare
      int L;
      logic e_r, e_en, e_we;
      if (ddr_valid) ddr_pulses++;
      if (chk_en) begin
         L    = m_dev ? 1 : MEM_LAT + 1;
         e_r  = m_busy && (m_age == L) && reset;
         e_en = m_busy && !m_dev && (m_age <= MEM_LAT);
         e_we = e_en && (m_age == MEM_LAT) && m_rw && mio_en && reset;
         check("r", {31'b0, r}, {31'b0, e_r});
         check("mem_en", {31'b0, mem_en}, {31'b0, e_en});
         check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
         check("mar_out", {16'b0, mar_out}, {16'b0, m_mar});
         check("mem_addr", {16'b0, mem_addr}, {16'b0, m_mar});
         check("mdr_out", {16'b0, mdr_out}, {16'b0, m_mdr});
         check("mem_wdata", {16'b0, mem_wdata}, {16'b0, m_mdr});
         check("ddr_valid", {31'b0, ddr_valid}, {31'b0, m_ddr_valid});
         check("ddr_data", {24'b0, ddr_data}, {24'b0, m_ddr});
         check("kbd_int", {31'b0, kbd_int}, {31'b0, m_full & m_ie});
      end
   end

   task automatic tick;
      @(posedge i_Clk);
      #1;
   endtask

   task automatic set_mar(input logic [15:0] a);
      bus_in = a; ld_mar = 1'b1; tick; ld_mar = 1'b0;
   endtask

   task automatic set_mdr(input logic [15:0] d);
      bus_in = d; ld_mdr = 1'b1; mio_en = 1'b0; tick; ld_mdr = 1'b0;
   endtask

   task automatic kbd(input logic [7:0] ch);
      kbd_data = ch; kbd_valid = 1'b1; tick; kbd_valid = 1'b0;
   endtask

   // Runs one access; cycle 0 is the request cycle. Bounded at 12 cycles.
   task automatic access(input logic wr, input logic ld, input int kbd_at, input int dsp_at,
                         input int drop_at, input int rst_at,
                         output int lat, output int en_n, output int we_n, output int we_c,
                         output logic [15:0] we_d);
      int c;
      lat = -1; en_n = 0; we_n = 0; we_c = -1; we_d = '0; c = 0;
      rw = wr; ld_mdr = ld; mio_en = 1'b1;
      kbd_valid = (kbd_at == 0); dsp_ready = (dsp_at == 0);
      while (c < 12 && lat < 0) begin
         @(negedge i_Clk);
         if (mem_en) en_n++;
         if (mem_we) begin we_n++; we_c = c; we_d = mem_wdata; end
         if (r) lat = c;
         tick;
         c++;
         kbd_valid = (c == kbd_at);
         dsp_ready = (c == dsp_at);
         if (c == drop_at) mio_en = 1'b0;
         reset = (c != rst_at);
         if (c == rst_at) mio_en = 1'b0;
      end
      mio_en = 1'b0; ld_mdr = 1'b0; rw = 1'b0; kbd_valid = 1'b0; dsp_ready = 1'b0; reset = 1'b1;
   endtask

   int lat, en_n, we_n, we_c;
   logic [15:0] we_d;

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
      set_mar(a);
      access(1'b0, 1'b1, -1, -1, -1, -1, lat, en_n, we_n, we_c, we_d);
      check({name, "_lat"}, lat, is_dev(a) ? 1 : MEM_LAT + 1);
      check(name, {16'b0, mdr_out}, {16'b0, exp});
   endtask

   initial begin
      int p0;
      repeat (2) tick;
      chk_en = 1'b1;
      tick;
      check("rst_mar", {16'b0, mar_out}, 32'h0);
      check("rst_mdr", {16'b0, mdr_out}, 32'h0);
      check("rst_strobes", {28'b0, r, mem_en, mem_we, ddr_valid}, 32'h0);
      reset = 1'b1;
      tick;
      rd(A_DSR, 16'h8000, "rst_dsr");

      // Memory read and write with wait states
      rdata_v = 16'hBEEF;
      set_mar(16'h3000);
      access(1'b0, 1'b1, -1, -1, -1, -1, lat, en_n, we_n, we_c, we_d);
      check("mrd_lat", lat, 5);
      check("mrd_en_cycles", en_n, 4);
      check("mrd_no_we", we_n, 0);
      check("mrd_mdr", {16'b0, mdr_out}, 32'hBEEF);
      set_mdr(16'h1234);
      set_mar(16'h3002);
      access(1'b1, 1'b0, -1, -1, -1, -1, lat, en_n, we_n, we_c, we_d);
      check("mwr_lat", lat, 5);
      check("mwr_we_cycles", we_n, 1);
      check("mwr_we_at", we_c, 4);
      check("mwr_wdata", {16'b0, we_d}, 32'h1234);

      // Keyboard, overrun and a character arriving during a KBDR read
      kbd(8'h41);
      rd(A_KBSR, 16'h8000, "kbsr_full");
      rd(A_KBDR, 16'h0041, "kbdr_rd");
      rd(A_KBSR, 16'h0000, "kbsr_empty");
      kbd(8'h41);
      kbd(8'h42);
      check("ovr_set", {31'b0, dut.r_kb_ovr}, 32'h1);
      rd(A_KBDR, 16'h0041, "ovr_kbdr");
      check("ovr_clr", {31'b0, dut.r_kb_ovr}, 32'h0);
      kbd(8'h55);
      kbd_data = 8'h66;
      set_mar(A_KBDR);
      access(1'b0, 1'b1, 1, -1, -1, -1, lat, en_n, we_n, we_c, we_d);
      check("coinc_old", {16'b0, mdr_out}, 32'h0055);
      rd(A_KBSR, 16'h8000, "coinc_full");
      rd(A_KBDR, 16'h0066, "coinc_new");

      // Display write with coincident dsp_ready, then ready again
      p0 = ddr_pulses;
      set_mdr(16'h0058);
      set_mar(A_DDR);
      access(1'b1, 1'b0, -1, 1, -1, -1, lat, en_n, we_n, we_c, we_d);
      check("ddr_lat", lat, 1);
      check("ddr_no_mem_en", en_n, 0);
      tick; tick;
      check("ddr_pulse", ddr_pulses - p0, 1);
      check("ddr_data", {24'b0, ddr_data}, 32'h58);
      rd(A_DSR, 16'h0000, "dsr_busy");
      dsp_ready = 1'b1; tick; dsp_ready = 1'b0;
      rd(A_DSR, 16'h8000, "dsr_ready");
      rd(A_DDR, 16'h0000, "ddr_rd");

      // Abort by mio_en and by reset on the 2nd MEM cycle of a write
      set_mdr(16'hAAAA);
      set_mar(16'h4000);
      access(1'b1, 1'b0, -1, -1, 2, -1, lat, en_n, we_n, we_c, we_d);
      check("abort_no_we", we_n, 0);
      check("abort_no_r", lat, -1);
      rd(A_DSR, 16'h8000, "abort_idle");
      rd(16'h3000, 16'hBEEF, "abort_mem");
      set_mdr(16'hAAAA);
      set_mar(16'h4000);
      access(1'b1, 1'b0, -1, -1, -1, 2, lat, en_n, we_n, we_c, we_d);
      check("rstmid_no_we", we_n, 0);
      check("rstmid_no_r", lat, -1);
      check("rstmid_mar", {16'b0, mar_out}, 32'h0);
      rd(16'h3000, 16'hBEEF, "rstmid_mem");

      // Keyboard interrupt enable
      set_mdr(16'h4000);
      set_mar(A_KBSR);
      access(1'b1, 1'b0, -1, -1, -1, -1, lat, en_n, we_n, we_c, we_d);
      check("kint_off", {31'b0, kbd_int}, 32'h0);
      kbd(8'h33);
      check("kint_on", {31'b0, kbd_int}, 32'h1);
      rd(A_KBDR, 16'h0033, "kint_kbdr");
      check("kint_clr", {31'b0, kbd_int}, 32'h0);

      tick;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
